water_lamp_multi_mode: RTL and testbench



---
 rtl/water_lamp_pkg.sv | 30 +++
 rtl/step_prescaler.sv | 36 +++
 rtl/water_lamp_multi_mode.sv | 106 ++++++++++
 tb/tb_water_lamp_multi_mode.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/water_lamp_pkg.sv
// Shared types and helpers for the multi-mode water lamp.
package water_lamp_pkg;

  localparam int unsigned MaxLedNum = 32;

  typedef enum logic [1:0] {
    ROT_L     = 2'd0,
    ROT_R     = 2'd1,
    PING_PONG = 2'd2,
    FILL      = 2'd3
  } lamp_mode_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } lamp_dir_e;

  // Starting pattern of each mode; only ROT_R begins at the MSB end.
  function automatic logic [MaxLedNum-1:0] init_pattern(lamp_mode_e mode, int unsigned led_num);
    logic [MaxLedNum-1:0] pat;
    pat = '0;
    if (mode == ROT_R) begin
      pat = {{(MaxLedNum-1){1'b0}}, 1'b1} << (led_num - 1);
    end else begin
      pat = {{(MaxLedNum-1){1'b0}}, 1'b1};
    end
    return pat;
  endfunction

endpackage

// File: rtl/step_prescaler.sv
// Free-running step prescaler: tick marks the last cycle of each STEP_CYCLES period.
module step_prescaler #(
  parameter int unsigned STEP_CYCLES = 25_000_000
) (
  input  logic clk_50mhz,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CntW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(STEP_CYCLES - 1);

  logic [CntW-1:0] count_q, count_d;

  assign tick = en && (count_q == LastCnt);

  always_comb begin
    count_d = count_q;
    if (clr || tick) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/water_lamp_multi_mode.sv
// Multi-mode water lamp: rotate left/right, ping-pong and fill patterns over LED_NUM LEDs,
// advanced once per prescaler period, with pause, clean mode switching and polarity select.
module water_lamp_multi_mode
  import water_lamp_pkg::*;
#(
  parameter int unsigned LED_NUM        = 4,
  parameter int unsigned STEP_CYCLES    = 25_000_000,
  parameter bit          LED_ACTIVE_LOW = 1'b0
) (
  input  logic               clk_50mhz,
  input  logic               rst,
  input  logic               en,
  input  logic [1:0]         mode,
  output logic [LED_NUM-1:0] led_out,
  output logic               step_pulse
);

  localparam logic [LED_NUM-1:0] PolMask      = {LED_NUM{LED_ACTIVE_LOW}};
  localparam logic [LED_NUM-1:0] ResetPattern = LED_NUM'(init_pattern(ROT_L, LED_NUM));

  lamp_mode_e         mode_in;
  lamp_mode_e         mode_q, mode_d;
  lamp_dir_e          dir_q, dir_d;
  logic [LED_NUM-1:0] pattern_q, pattern_d;
  logic [LED_NUM-1:0] led_q;
  logic [LED_NUM-1:0] shifted;
  logic               step_pulse_q, step_d;
  logic               mode_change;
  logic               tick;

  assign mode_in     = lamp_mode_e'(mode);
  assign mode_change = (mode_in != mode_q);

  // A mode change clears the prescaler so the new pattern gets a full first step.
  step_prescaler #(
    .STEP_CYCLES(STEP_CYCLES)
  ) u_prescaler (
    .clk_50mhz(clk_50mhz),
    .rst      (rst),
    .en       (en),
    .clr      (mode_change),
    .tick     (tick)
  );

  always_comb begin
    mode_d    = mode_q;
    pattern_d = pattern_q;
    dir_d     = dir_q;
    step_d    = 1'b0;
    shifted   = '0;
    if (mode_change) begin
      // Overrides a coincident tick: that step is dropped and no strobe is raised.
      mode_d    = mode_in;
      pattern_d = LED_NUM'(init_pattern(mode_in, LED_NUM));
      dir_d     = DIR_LEFT;
    end else if (tick) begin
      step_d = 1'b1;
      unique case (mode_q)
        ROT_L: pattern_d = {pattern_q[LED_NUM-2:0], pattern_q[LED_NUM-1]};
        ROT_R: pattern_d = {pattern_q[0], pattern_q[LED_NUM-1:1]};
        PING_PONG: begin
          // Turn around on the step that lands on an end, so the end LED shows once.
          if (dir_q == DIR_LEFT) begin
            shifted = pattern_q << 1;
            if (shifted[LED_NUM-1]) dir_d = DIR_RIGHT;
          end else begin
            shifted = pattern_q >> 1;
            if (shifted[0]) dir_d = DIR_LEFT;
          end
          pattern_d = shifted;
        end
        FILL: begin
          if (&pattern_q) begin
            pattern_d = '0;
          end else begin
            pattern_d = {pattern_q[LED_NUM-2:0], 1'b1};
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      mode_q       <= ROT_L;
      pattern_q    <= ResetPattern;
      dir_q        <= DIR_LEFT;
      step_pulse_q <= 1'b0;
      led_q        <= ResetPattern ^ PolMask;
    end else begin
      mode_q       <= mode_d;
      pattern_q    <= pattern_d;
      dir_q        <= dir_d;
      step_pulse_q <= step_d;
      led_q        <= pattern_d ^ PolMask;
    end
  end

  assign led_out    = led_q;
  assign step_pulse = step_pulse_q;

  // Only FILL may show an empty or multi-LED pattern.
  assert property (@(posedge clk_50mhz) disable iff (rst)
                   (mode_q != FILL) |-> $onehot(pattern_q));

endmodule

// File: tb/tb_water_lamp_multi_mode.sv
// Scoreboard bench: stimulus queues expected step events and sampled states by cycle number;
// one monitor compares them against two lamps (active-high and active-low).
module tb_water_lamp_multi_mode;

  logic       clk_50mhz = 1'b0;
  always #5 clk_50mhz = ~clk_50mhz;

  logic       rst, en;
  logic [1:0] mode;
  logic [3:0] led_out;
  logic       step_pulse;

  logic       rst2, en2;
  logic [1:0] mode2;
  logic [3:0] led_out2;
  logic       step_pulse2;

  water_lamp_multi_mode #(
    .LED_NUM       (4),
    .STEP_CYCLES   (5),
    .LED_ACTIVE_LOW(1'b0)
  ) dut (
    .clk_50mhz (clk_50mhz),
    .rst       (rst),
    .en        (en),
    .mode      (mode),
    .led_out   (led_out),
    .step_pulse(step_pulse)
  );

  water_lamp_multi_mode #(
    .LED_NUM       (4),
    .STEP_CYCLES   (5),
    .LED_ACTIVE_LOW(1'b1)
  ) dut_low (
    .clk_50mhz (clk_50mhz),
    .rst       (rst2),
    .en        (en2),
    .mode      (mode2),
    .led_out   (led_out2),
    .step_pulse(step_pulse2)
  );

  typedef struct {
    int         at;
    logic [3:0] led;
    logic       step;
  } exp_t;

  exp_t step_q[$];
  exp_t step2_q[$];
  exp_t chk_q[$];
  exp_t chk2_q[$];

  int cyc    = 0;
  int checks = 0;
  int errors = 0;
  bit done   = 1'b0;

  always @(posedge clk_50mhz) cyc <= cyc + 1;

  function automatic exp_t mk(input int at, input logic [3:0] led, input logic step);
    exp_t e;
    e.at   = at;
    e.led  = led;
    e.step = step;
    return e;
  endfunction

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk_50mhz);
  endtask

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, want, cyc);
    end
  endtask

  // Monitor: compares every strobe and every scheduled sample, then closes the run.
  always @(negedge clk_50mhz) begin
    exp_t e;
    if (step_pulse === 1'b1) begin
      if (step_q.size() == 0) begin
        cmp("unexpected_step", {28'd0, led_out}, 32'hffff_ffff);
      end else begin
        e = step_q.pop_front();
        cmp("step_led", {28'd0, led_out}, {28'd0, e.led});
        cmp("step_cycle", cyc, e.at);
      end
    end
    if (step_pulse2 === 1'b1) begin
      if (step2_q.size() == 0) begin
        cmp("low_unexpected_step", {28'd0, led_out2}, 32'hffff_ffff);
      end else begin
        e = step2_q.pop_front();
        cmp("low_step_led", {28'd0, led_out2}, {28'd0, e.led});
        cmp("low_step_cycle", cyc, e.at);
      end
    end
    while (chk_q.size() > 0 && chk_q[0].at <= cyc) begin
      e = chk_q.pop_front();
      cmp("state_cycle", cyc, e.at);
      cmp("state_led", {28'd0, led_out}, {28'd0, e.led});
      cmp("state_step", {31'd0, step_pulse}, {31'd0, e.step});
    end
    while (chk2_q.size() > 0 && chk2_q[0].at <= cyc) begin
      e = chk2_q.pop_front();
      cmp("low_state_cycle", cyc, e.at);
      cmp("low_state_led", {28'd0, led_out2}, {28'd0, e.led});
      cmp("low_state_step", {31'd0, step_pulse2}, {31'd0, e.step});
    end
    if (done) begin
      cmp("steps_left", step_q.size(), 0);
      cmp("low_steps_left", step2_q.size(), 0);
      cmp("states_left", chk_q.size() + chk2_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  // Active-high lamp: mode sequences, mode change on a tick, pause/resume.
  initial begin
    rst  = 1'b1;
    en   = 1'b0;
    mode = 2'd0;
    chk_q.push_back(mk(2, 4'b0001, 1'b0));
    wait_until(2);
    rst = 1'b0;
    en  = 1'b1;
    step_q.push_back(mk(7,  4'b0010, 1'b1));
    step_q.push_back(mk(12, 4'b0100, 1'b1));
    step_q.push_back(mk(17, 4'b1000, 1'b1));
    step_q.push_back(mk(22, 4'b0001, 1'b1));
    step_q.push_back(mk(27, 4'b0010, 1'b1));
    wait_until(27);

    mode = 2'd2;
    chk_q.push_back(mk(28, 4'b0001, 1'b0));
    step_q.push_back(mk(33, 4'b0010, 1'b1));
    step_q.push_back(mk(38, 4'b0100, 1'b1));
    step_q.push_back(mk(43, 4'b1000, 1'b1));
    step_q.push_back(mk(48, 4'b0100, 1'b1));
    step_q.push_back(mk(53, 4'b0010, 1'b1));
    step_q.push_back(mk(58, 4'b0001, 1'b1));
    step_q.push_back(mk(63, 4'b0010, 1'b1));
    wait_until(63);

    mode = 2'd3;
    chk_q.push_back(mk(64, 4'b0001, 1'b0));
    step_q.push_back(mk(69, 4'b0011, 1'b1));
    step_q.push_back(mk(74, 4'b0111, 1'b1));
    step_q.push_back(mk(79, 4'b1111, 1'b1));
    step_q.push_back(mk(84, 4'b0000, 1'b1));
    step_q.push_back(mk(89, 4'b0001, 1'b1));
    wait_until(89);

    // Switch to ROT_R exactly on the tick that would leave 0100.
    mode = 2'd0;
    chk_q.push_back(mk(90, 4'b0001, 1'b0));
    step_q.push_back(mk(95, 4'b0010, 1'b1));
    step_q.push_back(mk(100, 4'b0100, 1'b1));
    wait_until(104);
    mode = 2'd1;
    chk_q.push_back(mk(105, 4'b1000, 1'b0));
    step_q.push_back(mk(110, 4'b0100, 1'b1));
    wait_until(110);

    // Pause two counts into the period; resume needs only the remaining three.
    mode = 2'd0;
    chk_q.push_back(mk(111, 4'b0001, 1'b0));
    step_q.push_back(mk(116, 4'b0010, 1'b1));
    wait_until(118);
    en = 1'b0;
    chk_q.push_back(mk(128, 4'b0010, 1'b0));
    chk_q.push_back(mk(138, 4'b0010, 1'b0));
    wait_until(138);
    en = 1'b1;
    step_q.push_back(mk(141, 4'b0100, 1'b1));
    wait_until(141);
    en = 1'b0;
    chk_q.push_back(mk(146, 4'b0100, 1'b0));
    wait_until(150);
    done = 1'b1;
  end

  // Active-low lamp: reset value, mid-run reset at 1000, first step after release.
  initial begin
    rst2  = 1'b1;
    en2   = 1'b0;
    mode2 = 2'd0;
    chk2_q.push_back(mk(2, 4'b1110, 1'b0));
    wait_until(2);
    rst2 = 1'b0;
    en2  = 1'b1;
    step2_q.push_back(mk(7,  4'b1101, 1'b1));
    step2_q.push_back(mk(12, 4'b1011, 1'b1));
    step2_q.push_back(mk(17, 4'b0111, 1'b1));
    wait_until(19);
    rst2 = 1'b1;
    chk2_q.push_back(mk(20, 4'b1110, 1'b0));
    wait_until(20);
    rst2 = 1'b0;
    step2_q.push_back(mk(25, 4'b1101, 1'b1));
    wait_until(25);
    en2 = 1'b0;
  end

  initial begin
    #5000;
    $display("FAIL watchdog: no summary by time %0t", $time);
    $fatal(1);
  end

endmodule
